// File: rtl/aes_gcm_pkg.sv
// Shared types, constants and the block padding helper for the AES-GCM front end.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package aes_gcm_pkg;

    localparam int BLOCK_BYTES = 16;

    // Byte 0 of a block sits in bits [0:7], so bit 0 is the leftmost bit.
    typedef logic [0:127] block_t;
    typedef logic [0:127] key_t;
    typedef logic [0:95]  iv_t;

    typedef enum logic [1:0] {
        IDLE,
        AAD,
        PT,
        EMPTY
    } sched_state_t;

    // Zero every byte whose index is at or beyond valid_bytes; 16 keeps the whole block.
    function automatic block_t fn_pad_block(block_t blk, logic [4:0] valid_bytes);
        block_t r;
        r = blk;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (5'(i) >= valid_bytes) begin
                r[8*i +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_gcm_instance_scheduler_if.sv
// Header, data and stage-1 beat signals of the instance scheduler.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on header and data channels; the beat side has no ready.
interface aes_gcm_instance_scheduler_if
    import aes_gcm_pkg::*;
#(
    parameter int LEN_W = 32
) ();

    logic               i_hdr_valid;
    logic               o_hdr_ready;
    key_t               i_hdr_key;
    iv_t                i_hdr_iv;
    logic [LEN_W-1:0]   i_hdr_aad_bytes;
    logic [LEN_W-1:0]   i_hdr_pt_bytes;

    logic               i_data_valid;
    logic               o_data_ready;
    block_t             i_data;

    logic               o_valid;
    key_t               o_cipher_key;
    iv_t                o_iv;
    logic [127:0]       o_instance_size;
    block_t             o_aad;
    block_t             o_plain_text;
    logic               o_new_instance;
    logic               o_pt_instance;
    logic               o_busy;

    // Upstream source side (header/data producer, observer of the beats).
    modport master (
        output i_hdr_valid, i_hdr_key, i_hdr_iv, i_hdr_aad_bytes, i_hdr_pt_bytes,
        output i_data_valid, i_data,
        input  o_hdr_ready, o_data_ready,
        input  o_valid, o_cipher_key, o_iv, o_instance_size, o_aad, o_plain_text,
        input  o_new_instance, o_pt_instance, o_busy
    );

    // Scheduler side.
    modport slave (
        input  i_hdr_valid, i_hdr_key, i_hdr_iv, i_hdr_aad_bytes, i_hdr_pt_bytes,
        input  i_data_valid, i_data,
        output o_hdr_ready, o_data_ready,
        output o_valid, o_cipher_key, o_iv, o_instance_size, o_aad, o_plain_text,
        output o_new_instance, o_pt_instance, o_busy
    );

endinterface

// File: rtl/aes_gcm_seg_counter.sv
// Remaining-byte counter for one segment (AAD or PT); flags the last block and its valid bytes.
// Latency: outputs reflect the count held in the register; load/decrement take effect next cycle.
// Backpressure: none; decrements only on beats the parent accepts.
module aes_gcm_seg_counter
    import aes_gcm_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             is_last,
    output logic [4:0]       valid_bytes
);

    logic [LEN_W-1:0] rem_q;

    // A block with 16 or fewer bytes remaining closes the segment; exactly 16 still passes whole.
    always_comb begin
        is_last     = (rem_q <= LEN_W'(BLOCK_BYTES));
        valid_bytes = is_last ? rem_q[4:0] : 5'(BLOCK_BYTES);
    end

    // Load wins over decrement so the AAD->PT reload on the last AAD beat takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else if (load) begin
            rem_q <= load_val;
        end else if (dec) begin
            rem_q <= is_last ? '0 : rem_q - LEN_W'(BLOCK_BYTES);
        end
    end

endmodule

// File: rtl/aes_gcm_instance_scheduler.sv
// Turns one instance header plus a block stream into padded AAD then PT beats for stage 1.
// Latency: 1 cycle from data handshake to beat; EMPTY beat appears 2 cycles after header handshake.
// Backpressure: header ready only in IDLE, data ready only in AAD/PT; beats cannot be stalled.
module aes_gcm_instance_scheduler
    import aes_gcm_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    aes_gcm_instance_scheduler_if.slave   bus
);

    sched_state_t     state_q;
    sched_state_t     state_d;

    logic             hdr_hs;
    logic             data_hs;
    logic             beat;
    logic [LEN_W-1:0] pt_rem_q;
    logic             first_pending_q;

    logic             cnt_load;
    logic [LEN_W-1:0] cnt_load_val;
    logic             cnt_is_last;
    logic [4:0]       cnt_valid_bytes;
    block_t           padded;

    // Readiness follows the registered state and drops immediately while reset is held.
    assign bus.o_hdr_ready  = (state_q == IDLE) && !rst;
    assign bus.o_data_ready = ((state_q == AAD) || (state_q == PT)) && !rst;
    assign bus.o_busy       = (state_q != IDLE);

    assign hdr_hs  = bus.i_hdr_valid  && bus.o_hdr_ready;
    assign data_hs = bus.i_data_valid && bus.o_data_ready;
    assign beat    = data_hs || (state_q == EMPTY);
    assign padded  = fn_pad_block(bus.i_data, cnt_valid_bytes);

    aes_gcm_seg_counter #(
        .LEN_W (LEN_W)
    ) u_seg_counter (
        .clk         (clk),
        .rst         (rst),
        .load        (cnt_load),
        .load_val    (cnt_load_val),
        .dec         (data_hs),
        .is_last     (cnt_is_last),
        .valid_bytes (cnt_valid_bytes)
    );

    // Next-state decision and segment-counter (re)load control.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            IDLE: begin
                if (hdr_hs) begin
                    cnt_load = 1'b1;
                    if (bus.i_hdr_aad_bytes != '0) begin
                        state_d      = AAD;
                        cnt_load_val = bus.i_hdr_aad_bytes;
                    end else if (bus.i_hdr_pt_bytes != '0) begin
                        state_d      = PT;
                        cnt_load_val = bus.i_hdr_pt_bytes;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            AAD: begin
                if (data_hs && cnt_is_last) begin
                    if (pt_rem_q != '0) begin
                        state_d      = PT;
                        cnt_load     = 1'b1;
                        cnt_load_val = pt_rem_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            PT: begin
                if (data_hs && cnt_is_last) begin
                    state_d = IDLE;
                end
            end
            EMPTY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-instance context: captured on the header handshake and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_cipher_key    <= '0;
            bus.o_iv            <= '0;
            bus.o_instance_size <= '0;
            pt_rem_q            <= '0;
            first_pending_q     <= 1'b0;
        end else if (hdr_hs) begin
            bus.o_cipher_key    <= bus.i_hdr_key;
            bus.o_iv            <= bus.i_hdr_iv;
            bus.o_instance_size <= {64'(bus.i_hdr_aad_bytes) << 3, 64'(bus.i_hdr_pt_bytes) << 3};
            pt_rem_q            <= bus.i_hdr_pt_bytes;
            first_pending_q     <= 1'b1;
        end else if (beat) begin
            first_pending_q     <= 1'b0;
        end
    end

    // Beat outputs: data fields are zero on every cycle that is not a beat of that segment.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_valid        <= 1'b0;
            bus.o_new_instance <= 1'b0;
            bus.o_pt_instance  <= 1'b0;
            bus.o_aad          <= '0;
            bus.o_plain_text   <= '0;
        end else begin
            bus.o_valid        <= beat;
            bus.o_new_instance <= beat && first_pending_q;
            bus.o_pt_instance  <= data_hs && (state_q == PT);
            bus.o_aad          <= (data_hs && (state_q == AAD)) ? padded : '0;
            bus.o_plain_text   <= (data_hs && (state_q == PT))  ? padded : '0;
        end
    end

endmodule
